// File: rtl/limn2600_pkg.sv
// Shared definitions for the Limn2600 interval timer: register map, CTRL bit
// positions, bus FSM encoding and reset values.
package limn2600_pkg;

  localparam logic [1:0] REG_CTRL    = 2'd0;
  localparam logic [1:0] REG_COUNT   = 2'd1;
  localparam logic [1:0] REG_COMPARE = 2'd2;
  localparam logic [1:0] REG_STATUS  = 2'd3;

  localparam int CTRL_EN_BIT   = 0;
  localparam int CTRL_IE_BIT   = 1;
  localparam int CTRL_AUTO_BIT = 2;

  localparam logic [31:0] COMPARE_RST = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  // CTRL read value: only EN/IE/AUTO are implemented, upper bits read 0.
  function automatic logic [31:0] ctrl_word(input logic [2:0] ctrl);
    ctrl_word = {29'd0, ctrl};
  endfunction

endpackage

// File: rtl/limn2600_tick_counter.sv
// Prescaler and 32-bit COUNT register; flags a match when a tick-updated COUNT
// equals COMPARE and arms the auto-reload for the following tick.
module limn2600_tick_counter
  import limn2600_pkg::*;
#(
  parameter int PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        en,
  input  logic        auto_reload,
  input  logic        presc_clr,
  input  logic        count_wr,
  input  logic [31:0] count_wdata,
  input  logic [31:0] compare,
  output logic [31:0] count,
  output logic        match
);

  localparam logic [15:0] PRESC_MAX = 16'(PRESCALE - 1);

  logic [15:0] presc_q, presc_d;
  logic [31:0] count_q, count_d;
  logic        reload_q, reload_d;
  logic        tick_s;
  logic        match_s;

  // Next-state for prescaler, COUNT and pending auto-reload; CPU writes beat ticks.
  always_comb begin
    tick_s   = en && (presc_q == PRESC_MAX);
    presc_d  = presc_q;
    count_d  = count_q;
    reload_d = reload_q;
    match_s  = 1'b0;
    if (!en || presc_clr || tick_s) begin
      presc_d = 16'd0;
    end else begin
      presc_d = presc_q + 16'd1;
    end
    if (count_wr) begin
      count_d  = count_wdata;
      reload_d = 1'b0;
    end else if (tick_s) begin
      if (reload_q) begin
        count_d = 32'd0;
      end else begin
        count_d = count_q + 32'd1;
      end
      match_s  = (count_d == compare);
      reload_d = match_s && auto_reload;
    end else begin
      count_d  = count_q;
      reload_d = reload_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      presc_q  <= 16'd0;
      count_q  <= 32'd0;
      reload_q <= 1'b0;
    end else begin
      presc_q  <= presc_d;
      count_q  <= count_d;
      reload_q <= reload_d;
    end
  end

  assign count = count_q;
  assign match = match_s;

endmodule

// File: rtl/limn2600_timer.sv
// Limn2600 memory-mapped interval timer: bus FSM with one-cycle acknowledge,
// CTRL/COMPARE/STATUS registers and level interrupt.
module limn2600_timer
  import limn2600_pkg::*;
#(
  parameter logic [31:0] BASE     = 32'hF800_0000,
  parameter int          PRESCALE = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        we,
  input  logic [31:0] addr,
  input  logic [31:0] data_in,
  output logic [31:0] data_out,
  output logic        rdy,
  output logic        hit,
  output logic        irq
);

  logic [1:0]  rst_sync_q;
  logic        rst_n_s;
  bus_state_e  state_q, state_d;
  logic        we_q, we_d;
  logic [1:0]  sel_q, sel_d;
  logic [2:0]  ctrl_q, ctrl_d;
  logic [31:0] compare_q, compare_d;
  logic        pend_q, pend_d;
  logic        hit_s, wr_s;
  logic        ctrl_wr_s, count_wr_s, compare_wr_s, status_wr_s;
  logic        en_rise_s, match_s;
  logic [31:0] count_s, rd_data_s;
  logic        unused_addr_s;

  assign unused_addr_s = ^addr[1:0];

  // Reset asserts immediately and releases two clock edges after rst rises.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rst_sync_q <= 2'b00;
    end else begin
      rst_sync_q <= {rst_sync_q[0], 1'b1};
    end
  end
  assign rst_n_s = rst_sync_q[1];

  assign hit_s = cs && (addr[31:4] == BASE[31:4]);
  assign hit   = hit_s;

  // Bus FSM: one acknowledge per cs assertion; writes commit on the IDLE->ACK edge.
  always_comb begin
    state_d = state_q;
    we_d    = we_q;
    sel_d   = sel_q;
    wr_s    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (hit_s) begin
          state_d = ST_ACK;
          we_d    = we;
          sel_d   = addr[3:2];
          wr_s    = we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_ACK:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (!cs) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign ctrl_wr_s    = wr_s && (addr[3:2] == REG_CTRL);
  assign count_wr_s   = wr_s && (addr[3:2] == REG_COUNT);
  assign compare_wr_s = wr_s && (addr[3:2] == REG_COMPARE);
  assign status_wr_s  = wr_s && (addr[3:2] == REG_STATUS);
  assign en_rise_s    = ctrl_wr_s && data_in[CTRL_EN_BIT] && !ctrl_q[CTRL_EN_BIT];

  // Register file; a match sets PEND even against a same-edge clear.
  always_comb begin
    ctrl_d    = ctrl_q;
    compare_d = compare_q;
    pend_d    = pend_q;
    if (ctrl_wr_s) begin
      ctrl_d = data_in[2:0];
    end else begin
      ctrl_d = ctrl_q;
    end
    if (match_s && !ctrl_q[CTRL_AUTO_BIT]) begin
      ctrl_d[CTRL_EN_BIT] = 1'b0;
    end else begin
      ctrl_d[CTRL_EN_BIT] = ctrl_d[CTRL_EN_BIT];
    end
    if (compare_wr_s) begin
      compare_d = data_in;
    end else begin
      compare_d = compare_q;
    end
    if (match_s) begin
      pend_d = 1'b1;
    end else if (status_wr_s && data_in[0]) begin
      pend_d = 1'b0;
    end else begin
      pend_d = pend_q;
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge rst_n_s) begin
    if (!rst_n_s) begin
      state_q   <= ST_IDLE;
      we_q      <= 1'b0;
      sel_q     <= 2'd0;
      ctrl_q    <= 3'd0;
      compare_q <= COMPARE_RST;
      pend_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_q      <= we_d;
      sel_q     <= sel_d;
      ctrl_q    <= ctrl_d;
      compare_q <= compare_d;
      pend_q    <= pend_d;
    end
  end

  limn2600_tick_counter #(
    .PRESCALE(PRESCALE)
  ) u_tick (
    .clk         (clk),
    .rst_n       (rst_n_s),
    .en          (ctrl_q[CTRL_EN_BIT]),
    .auto_reload (ctrl_q[CTRL_AUTO_BIT]),
    .presc_clr   (en_rise_s || count_wr_s),
    .count_wr    (count_wr_s),
    .count_wdata (data_in),
    .compare     (compare_q),
    .count       (count_s),
    .match       (match_s)
  );

  // Read mux over the register captured at the start of the access.
  always_comb begin
    rd_data_s = 32'd0;
    case (sel_q)
      REG_CTRL:    rd_data_s = ctrl_word(ctrl_q);
      REG_COUNT:   rd_data_s = count_s;
      REG_COMPARE: rd_data_s = compare_q;
      REG_STATUS:  rd_data_s = {31'd0, pend_q};
      default:     rd_data_s = 32'd0;
    endcase
  end

  assign rdy      = (state_q == ST_ACK);
  assign data_out = (rdy && !we_q) ? rd_data_s : 32'd0;
  assign irq      = pend_q && ctrl_q[CTRL_IE_BIT];

endmodule
